// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared state encoding for the VALID/READY channel endpoints.
// Revision    : 1.0
// ============================================================================
package rx_pkg;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      EMPTY = 2'd1,
      ONE   = 2'd2,
      FULL  = 2'd3
   } rx_state_t;

endpackage : rx_pkg
`default_nettype wire

// File: rtl/rx_proto_chk.sv
`default_nettype none
// ============================================================================
// Module      : rx_proto_chk
// Description : Sticky detector for a source that drops VALID or changes its
//               payload while stalled.
// Revision    : 1.0
// ============================================================================
module rx_proto_chk #(
   parameter int WIDTH = 8
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             arm,
   input  logic             VALID,
   input  logic             READY,
   input  logic [WIDTH-1:0] xDATA,
   output logic             proto_err
);

   logic             r_stall;
   logic [WIDTH-1:0] r_data;
   logic             r_err;
   logic             w_stall;

   assign w_stall = arm & VALID & ~READY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_stall <= 1'b0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         // A stalled beat must be re-presented unchanged on the following edge.
         if (r_stall && (!VALID || (xDATA != r_data)))
            r_err <= 1'b1;
         r_stall <= w_stall;
         if (w_stall)
            r_data <= xDATA;
      end
   end

   assign proto_err = r_err;

endmodule : rx_proto_chk
`default_nettype wire

// File: rtl/rx_channel.sv
`default_nettype none
// ============================================================================
// Module      : rx_channel
// Description : Receive endpoint of a VALID/READY channel with a 2-entry skid
//               buffer, registered READY and a staged consumer interface.
// Revision    : 1.0
// ============================================================================
module rx_channel
   import rx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             VALID,
   input  logic [WIDTH-1:0] xDATA,
   output logic             READY,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_en,
   output logic             rx_hold,
   output logic             proto_err
);

   rx_state_t        r_state;
   logic             r_ready;
   logic             r_valid;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;

   logic             w_acc;
   logic             w_pop;
   logic             w_main_from_bus;
   logic             w_main_from_skid;
   logic             w_load_skid;

   assign w_acc = VALID & r_ready;
   assign w_pop = rx_en & r_valid;

   assign w_main_from_bus  = ((r_state == EMPTY) && w_acc) ||
                             ((r_state == ONE) && w_acc && w_pop);
   assign w_main_from_skid = (r_state == FULL) && w_pop;
   assign w_load_skid      = (r_state == ONE) && w_acc && !w_pop;

   // READY and rx_valid are registered alongside the state they describe.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state <= RST;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            RST: begin
               r_state <= EMPTY;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
            EMPTY: begin
               if (w_acc) begin
                  r_state <= ONE;
                  r_valid <= 1'b1;
               end
            end
            ONE: begin
               if (w_acc && !w_pop) begin
                  r_state <= FULL;
                  r_ready <= 1'b0;
               end else if (!w_acc && w_pop) begin
                  r_state <= EMPTY;
                  r_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_state <= ONE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= RST;
               r_ready <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // Payload registers carry no reset; rx_valid qualifies their contents.
   always_ff @(posedge ACLK) begin
      if (w_load_skid)
         r_skid <= xDATA;
      if (w_main_from_skid)
         r_main <= r_skid;
      else if (w_main_from_bus)
         r_main <= xDATA;
   end

   rx_proto_chk #(
      .WIDTH     (WIDTH)
   ) u_proto_chk (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .arm       (r_state != RST),
      .VALID     (VALID),
      .READY     (r_ready),
      .xDATA     (xDATA),
      .proto_err (proto_err)
   );

   assign READY    = r_ready;
   assign rx_valid = r_valid;
   assign rx_hold  = ~r_valid;
   assign rx_data  = r_main;

endmodule : rx_channel
`default_nettype wire
